// File: rtl/arbitro_rr.sv
// arbitro_rr: round-robin arbiter from four input FIFOs to four output FIFOs, routed by word[DW-1:DW-2].
// Define ARB_PUSH_CNT_EN to add per-output 8-bit push counters readable through cnt_sel/cnt_out.
module arbitro_rr #(
   parameter int unsigned DW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          empty_0,
   input  logic          empty_1,
   input  logic          empty_2,
   input  logic          empty_3,
   input  logic          alm_full_0,
   input  logic          alm_full_1,
   input  logic          alm_full_2,
   input  logic          alm_full_3,
   input  logic [DW-1:0] data_poped_0,
   input  logic [DW-1:0] data_poped_1,
   input  logic [DW-1:0] data_poped_2,
   input  logic [DW-1:0] data_poped_3,
   output logic          pop_0,
   output logic          pop_1,
   output logic          pop_2,
   output logic          pop_3,
   output logic          push_0,
   output logic          push_1,
   output logic          push_2,
   output logic          push_3,
   output logic [DW-1:0] data_pushed_0,
   output logic [DW-1:0] data_pushed_1,
   output logic [DW-1:0] data_pushed_2,
   output logic [DW-1:0] data_pushed_3,
`ifdef ARB_PUSH_CNT_EN
   input  logic [1:0]    cnt_sel,
   output logic [7:0]    cnt_out,
`endif
   output logic [1:0]    state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t        st;
   state_t        st_nxt;
   logic [3:0]    empty_v;
   logic [3:0]    alm_full_v;
   logic [3:0]    elig;
   logic [3:0]    pop_v;
   logic [3:0]    push_v;
   logic [1:0]    ptr;
   logic [1:0]    scan_idx;
   logic [1:0]    grant_idx;
   logic [1:0]    pop_idx;
   logic [1:0]    tag_idx;
   logic [1:0]    dest;
   logic          grant_ok;
   logic          tag_v;
   logic [DW-1:0] din  [4];
   logic [DW-1:0] dout [4];
   logic [DW-1:0] sample;

   assign empty_v    = {empty_3, empty_2, empty_1, empty_0};
   assign alm_full_v = {alm_full_3, alm_full_2, alm_full_1, alm_full_0};
   assign din[0]     = data_poped_0;
   assign din[1]     = data_poped_1;
   assign din[2]     = data_poped_2;
   assign din[3]     = data_poped_3;

   always_comb begin : next_state
      st_nxt = st;
      case (st)
         IDLE: begin
            if (en && !(&empty_v)) st_nxt = ARB;
         end
         ARB: begin
            if (|alm_full_v)              st_nxt = HOLD;
            else if (!en || (&empty_v))   st_nxt = IDLE;
         end
         HOLD: begin
            if (!en)                      st_nxt = IDLE;
            else if (!(|alm_full_v))      st_nxt = ARB;
         end
         default: st_nxt = IDLE;
      endcase
   end

   // A port popped this cycle still looks non-empty, so it sits out the next decision.
   always_comb begin : grant
      elig      = (st_nxt == ARB) ? (~empty_v & ~pop_v) : 4'b0000;
      grant_ok  = 1'b0;
      grant_idx = 2'd0;
      scan_idx  = 2'd0;
      for (int unsigned off = 0; off < 4; off++) begin
         scan_idx = ptr + 2'(off);
         if (!grant_ok && elig[scan_idx]) begin
            grant_ok  = 1'b1;
            grant_idx = scan_idx;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin : fsm
      if (rst) begin
         st      <= IDLE;
         pop_v   <= '0;
         pop_idx <= '0;
         ptr     <= '0;
      end else begin
         st    <= st_nxt;
         pop_v <= '0;
         if (grant_ok) begin
            pop_v[grant_idx] <= 1'b1;
            pop_idx          <= grant_idx;
            ptr              <= grant_idx + 2'd1;
         end
      end
   end

   assign sample = din[tag_idx];
   assign dest   = sample[DW-1:DW-2];

   // Words already popped always complete; only reset drops the tag.
   always_ff @(posedge clk or posedge rst) begin : route
      if (rst) begin
         tag_v   <= 1'b0;
         tag_idx <= '0;
         push_v  <= '0;
         for (int unsigned i = 0; i < 4; i++) dout[i] <= '0;
      end else begin
         tag_v   <= |pop_v;
         tag_idx <= pop_idx;
         push_v  <= '0;
         if (tag_v) begin
            push_v[dest] <= 1'b1;
            dout[dest]   <= sample;
         end
      end
   end

`ifdef ARB_PUSH_CNT_EN
   logic [7:0] cnt [4];

   always_ff @(posedge clk or posedge rst) begin : push_cnt
      if (rst) begin
         for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < 4; i++) cnt[i] <= cnt[i] + {7'd0, push_v[i]};
      end
   end

   assign cnt_out = cnt[cnt_sel];
`endif

   assign pop_0         = pop_v[0];
   assign pop_1         = pop_v[1];
   assign pop_2         = pop_v[2];
   assign pop_3         = pop_v[3];
   assign push_0        = push_v[0];
   assign push_1        = push_v[1];
   assign push_2        = push_v[2];
   assign push_3        = push_v[3];
   assign data_pushed_0 = dout[0];
   assign data_pushed_1 = dout[1];
   assign data_pushed_2 = dout[2];
   assign data_pushed_3 = dout[3];
   assign state         = st;

endmodule

// File: tb/tb_arbitro_rr.sv
// Self-checking bench for arbitro_rr: modelled input FIFOs feed the DUT, a scoreboard holds expected pops and pushes.
module tb_arbitro_rr;

   localparam int unsigned DW = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en  = 1'b0;
   logic [3:0]    empty = 4'hF;
   logic [3:0]    alm_full = 4'h0;
   logic [DW-1:0] dpo [4] = '{default: '0};
   logic          pop_0, pop_1, pop_2, pop_3;
   logic          push_0, push_1, push_2, push_3;
   logic [DW-1:0] dpu [4];
   logic [1:0]    state;
   logic [3:0]    pop_v, push_v;
`ifdef ARB_PUSH_CNT_EN
   logic [1:0]    cnt_sel = 2'd0;
   logic [7:0]    cnt_out;
`endif

   logic [DW-1:0] q0 [$];
   logic [DW-1:0] q1 [$];
   logic [DW-1:0] q2 [$];
   logic [DW-1:0] q3 [$];
   logic [3:0]    exp_pop [$];
   logic [DW-1:0] exp_push [$];
   int            compared = 0;
   int            mismatched = 0;

   assign pop_v  = {pop_3, pop_2, pop_1, pop_0};
   assign push_v = {push_3, push_2, push_1, push_0};

   arbitro_rr #(.DW(DW)) dut (
      .clk(clk), .rst(rst), .en(en),
      .empty_0(empty[0]), .empty_1(empty[1]), .empty_2(empty[2]), .empty_3(empty[3]),
      .alm_full_0(alm_full[0]), .alm_full_1(alm_full[1]),
      .alm_full_2(alm_full[2]), .alm_full_3(alm_full[3]),
      .data_poped_0(dpo[0]), .data_poped_1(dpo[1]), .data_poped_2(dpo[2]), .data_poped_3(dpo[3]),
      .pop_0(pop_0), .pop_1(pop_1), .pop_2(pop_2), .pop_3(pop_3),
      .push_0(push_0), .push_1(push_1), .push_2(push_2), .push_3(push_3),
      .data_pushed_0(dpu[0]), .data_pushed_1(dpu[1]), .data_pushed_2(dpu[2]), .data_pushed_3(dpu[3]),
`ifdef ARB_PUSH_CNT_EN
      .cnt_sel(cnt_sel), .cnt_out(cnt_out),
`endif
      .state(state)
   );

   always #5 clk = ~clk;

   // Input FIFO model: read data valid the cycle after pop, empty flag registered.
   always @(posedge clk) begin
      if (pop_0 && q0.size() != 0) dpo[0] <= q0.pop_front();
      if (pop_1 && q1.size() != 0) dpo[1] <= q1.pop_front();
      if (pop_2 && q2.size() != 0) dpo[2] <= q2.pop_front();
      if (pop_3 && q3.size() != 0) dpo[3] <= q3.pop_front();
      empty <= {q3.size() == 0, q2.size() == 0, q1.size() == 0, q0.size() == 0};
   end

   task automatic load(input int port, input logic [DW-1:0] w);
      case (port)
         0: q0.push_back(w);
         1: q1.push_back(w);
         2: q2.push_back(w);
         default: q3.push_back(w);
      endcase
   endtask

   task automatic expect_word(input int port, input logic [DW-1:0] w);
      logic [3:0] oh;
      oh = 4'b0001 << port;
      exp_pop.push_back(oh);
      exp_push.push_back(w);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en  = 1'b0;
      repeat (3) @(negedge clk);
      compared++;
      if (pop_v !== 4'h0) begin mismatched++; $display("FAIL reset_pop: got %b, expected 0000", pop_v); end
      compared++;
      if (push_v !== 4'h0) begin mismatched++; $display("FAIL reset_push: got %b, expected 0000", push_v); end
      compared++;
      if ({dpu[0], dpu[1], dpu[2], dpu[3]} !== '0) begin
         mismatched++; $display("FAIL reset_data: got %h %h %h %h, expected all 0", dpu[0], dpu[1], dpu[2], dpu[3]);
      end
      compared++;
      if (state !== 2'd0) begin mismatched++; $display("FAIL reset_state: got %0d, expected 0", state); end
      rst = 1'b0;
   endtask

   task automatic test_rotation();
      logic [DW-1:0] w [4];
      logic [3:0]    ep, ev;
      logic [DW-1:0] ew;
      int first_pop = -1, last_pop = -1, first_push = -1, last_push = -1;
      w[0] = 10'h311; w[1] = 10'h222; w[2] = 10'h133; w[3] = 10'h044;
      for (int p = 0; p < 4; p++) begin load(p, w[p]); expect_word(p, w[p]); end
      en = 1'b1;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (pop_v != 4'h0) begin
            if (first_pop < 0) first_pop = c;
            last_pop = c;
            compared++;
            if (exp_pop.size() == 0) begin mismatched++; $display("FAIL rot_pop: got %b, expected none", pop_v); end
            else begin
               ep = exp_pop.pop_front();
               if (pop_v !== ep) begin mismatched++; $display("FAIL rot_pop: got %b, expected %b", pop_v, ep); end
            end
         end
         if (push_v != 4'h0) begin
            if (first_push < 0) first_push = c;
            last_push = c;
            compared++;
            if (exp_push.size() == 0) begin mismatched++; $display("FAIL rot_push: got %b, expected none", push_v); end
            else begin
               ew = exp_push.pop_front();
               ev = 4'b0001 << ew[DW-1:DW-2];
               if (push_v !== ev || dpu[ew[DW-1:DW-2]] !== ew) begin
                  mismatched++; $display("FAIL rot_push: got %b/%h, expected %b/%h", push_v, dpu[ew[DW-1:DW-2]], ev, ew);
               end
            end
         end
      end
      compared++;
      if (last_pop - first_pop != 3) begin mismatched++; $display("FAIL rot_pop_span: got %0d, expected 3", last_pop - first_pop); end
      compared++;
      if (first_push - first_pop != 2) begin mismatched++; $display("FAIL rot_latency: got %0d, expected 2", first_push - first_pop); end
      compared++;
      if (last_push - first_push != 3) begin mismatched++; $display("FAIL rot_push_span: got %0d, expected 3", last_push - first_push); end
      compared++;
      if (exp_pop.size() != 0 || exp_push.size() != 0) begin
         mismatched++; $display("FAIL rot_leftover: got %0d/%0d pending, expected 0/0", exp_pop.size(), exp_push.size());
         exp_pop.delete(); exp_push.delete();
      end
      compared++;
      if (state !== 2'd0) begin mismatched++; $display("FAIL rot_state: got %0d, expected 0", state); end
   endtask

   task automatic test_single_port();
      logic [3:0]    ep, ev;
      logic [DW-1:0] ew;
      int first_pop = -1, last_pop = -1;
      load(2, 10'h1A5); load(2, 10'h2FF); load(2, 10'h003);
      expect_word(2, 10'h1A5); expect_word(2, 10'h2FF); expect_word(2, 10'h003);
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (pop_v != 4'h0) begin
            if (first_pop < 0) first_pop = c;
            last_pop = c;
            compared++;
            if (exp_pop.size() == 0) begin mismatched++; $display("FAIL single_pop: got %b, expected none", pop_v); end
            else begin
               ep = exp_pop.pop_front();
               if (pop_v !== ep) begin mismatched++; $display("FAIL single_pop: got %b, expected %b", pop_v, ep); end
            end
         end
         if (push_v != 4'h0) begin
            compared++;
            if (exp_push.size() == 0) begin mismatched++; $display("FAIL single_push: got %b, expected none", push_v); end
            else begin
               ew = exp_push.pop_front();
               ev = 4'b0001 << ew[DW-1:DW-2];
               if (push_v !== ev || dpu[ew[DW-1:DW-2]] !== ew) begin
                  mismatched++; $display("FAIL single_push: got %b/%h, expected %b/%h", push_v, dpu[ew[DW-1:DW-2]], ev, ew);
               end
            end
         end
      end
      compared++;
      if (last_pop - first_pop != 4) begin mismatched++; $display("FAIL single_spacing: got %0d, expected 4", last_pop - first_pop); end
      compared++;
      if (exp_pop.size() != 0 || exp_push.size() != 0) begin
         mismatched++; $display("FAIL single_leftover: got %0d/%0d pending, expected 0/0", exp_pop.size(), exp_push.size());
         exp_pop.delete(); exp_push.delete();
      end
   endtask

   task automatic test_alm_full_hold();
      logic [DW-1:0] w [4];
      logic [3:0]    ep, ev;
      logic [DW-1:0] ew;
      logic          raised = 1'b0;
      w[0] = 10'h1B0; w[1] = 10'h0B1; w[2] = 10'h3B2; w[3] = 10'h2B3;
      for (int p = 0; p < 4; p++) load(p, w[p]);
      expect_word(3, w[3]); expect_word(0, w[0]);
      for (int phase = 0; phase < 2; phase++) begin
         for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (pop_v != 4'h0) begin
               compared++;
               if (exp_pop.size() == 0) begin mismatched++; $display("FAIL hold_pop: got %b, expected none", pop_v); end
               else begin
                  ep = exp_pop.pop_front();
                  if (pop_v !== ep) begin mismatched++; $display("FAIL hold_pop: got %b, expected %b", pop_v, ep); end
               end
               if (pop_v[0] && !raised) begin alm_full[1] = 1'b1; raised = 1'b1; end
            end
            if (push_v != 4'h0) begin
               compared++;
               if (exp_push.size() == 0) begin mismatched++; $display("FAIL hold_push: got %b, expected none", push_v); end
               else begin
                  ew = exp_push.pop_front();
                  ev = 4'b0001 << ew[DW-1:DW-2];
                  if (push_v !== ev || dpu[ew[DW-1:DW-2]] !== ew) begin
                     mismatched++; $display("FAIL hold_push: got %b/%h, expected %b/%h", push_v, dpu[ew[DW-1:DW-2]], ev, ew);
                  end
               end
            end
         end
         compared++;
         if (state !== ((phase == 0) ? 2'd2 : 2'd0)) begin
            mismatched++; $display("FAIL hold_state%0d: got %0d, expected %0d", phase, state, (phase == 0) ? 2 : 0);
         end
         compared++;
         if (exp_pop.size() != 0 || exp_push.size() != 0) begin
            mismatched++; $display("FAIL hold_leftover%0d: got %0d/%0d pending, expected 0/0", phase, exp_pop.size(), exp_push.size());
            exp_pop.delete(); exp_push.delete();
         end
         alm_full[1] = 1'b0;
         expect_word(1, w[1]); expect_word(2, w[2]);
         if (phase == 1) begin exp_pop.delete(); exp_push.delete(); end
      end
   endtask

   task automatic test_en_drop();
      logic [3:0]    ep, ev;
      logic [DW-1:0] ew;
      int            npop = 0;
      for (int p = 0; p < 4; p++)
         for (int k = 0; k < 2; k++) load(p, {2'((p + k) % 4), 4'(p), 4'(k)});
      for (int k = 0; k < 2; k++)
         for (int j = 0; j < 4; j++) expect_word((3 + j) % 4, {2'(((3 + j) % 4 + k) % 4), 4'((3 + j) % 4), 4'(k)});
      for (int phase = 0; phase < 2; phase++) begin
         for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (pop_v != 4'h0) begin
               npop++;
               compared++;
               if (exp_pop.size() == 0) begin mismatched++; $display("FAIL en_pop: got %b, expected none", pop_v); end
               else begin
                  ep = exp_pop.pop_front();
                  if (pop_v !== ep) begin mismatched++; $display("FAIL en_pop: got %b, expected %b", pop_v, ep); end
               end
               if (npop == 3 && phase == 0) en = 1'b0;
            end
            if (push_v != 4'h0) begin
               compared++;
               if (exp_push.size() == 0) begin mismatched++; $display("FAIL en_push: got %b, expected none", push_v); end
               else begin
                  ew = exp_push.pop_front();
                  ev = 4'b0001 << ew[DW-1:DW-2];
                  if (push_v !== ev || dpu[ew[DW-1:DW-2]] !== ew) begin
                     mismatched++; $display("FAIL en_push: got %b/%h, expected %b/%h", push_v, dpu[ew[DW-1:DW-2]], ev, ew);
                  end
               end
            end
         end
         compared++;
         if (state !== 2'd0) begin mismatched++; $display("FAIL en_state%0d: got %0d, expected 0", phase, state); end
         if (phase == 0) begin
            compared++;
            if (exp_pop.size() < 4 || exp_pop.size() > 5) begin
               mismatched++; $display("FAIL en_extra_pops: got %0d pending, expected 4..5", exp_pop.size());
            end
            compared++;
            if (exp_push.size() != exp_pop.size()) begin
               mismatched++; $display("FAIL en_inflight: got %0d pushes pending, expected %0d", exp_push.size(), exp_pop.size());
            end
            en = 1'b1;
         end else begin
            compared++;
            if (exp_pop.size() != 0 || exp_push.size() != 0) begin
               mismatched++; $display("FAIL en_leftover: got %0d/%0d pending, expected 0/0", exp_pop.size(), exp_push.size());
               exp_pop.delete(); exp_push.delete();
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0]    ep, ev;
      logic [DW-1:0] ew;
      logic          seen = 1'b0;
      logic          leaked = 1'b0;
      load(1, 10'h3AA);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (pop_v[1]) begin seen = 1'b1; break; end
      end
      compared++;
      if (!seen) begin mismatched++; $display("FAIL mid_first_pop: got no pop_1 within 10 cycles, expected one"); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      compared++;
      if (pop_v !== 4'h0 || push_v !== 4'h0) begin
         mismatched++; $display("FAIL mid_strobes: got pop %b push %b, expected 0000/0000", pop_v, push_v);
      end
      compared++;
      if ({dpu[0], dpu[1], dpu[2], dpu[3]} !== '0) begin
         mismatched++; $display("FAIL mid_data: got %h %h %h %h, expected all 0", dpu[0], dpu[1], dpu[2], dpu[3]);
      end
      compared++;
      if (state !== 2'd0) begin mismatched++; $display("FAIL mid_state: got %0d, expected 0", state); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (push_v != 4'h0) leaked = 1'b1;
      end
      compared++;
      if (leaked) begin mismatched++; $display("FAIL mid_discard: got a push during reset, expected none"); end
      load(3, 10'h0C3); load(0, 10'h1C0);
      expect_word(0, 10'h1C0); expect_word(3, 10'h0C3);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (pop_v != 4'h0) begin
            compared++;
            if (exp_pop.size() == 0) begin mismatched++; $display("FAIL mid_pop: got %b, expected none", pop_v); end
            else begin
               ep = exp_pop.pop_front();
               if (pop_v !== ep) begin mismatched++; $display("FAIL mid_pop: got %b, expected %b", pop_v, ep); end
            end
         end
         if (push_v != 4'h0) begin
            compared++;
            if (exp_push.size() == 0) begin mismatched++; $display("FAIL mid_push: got %b, expected none", push_v); end
            else begin
               ew = exp_push.pop_front();
               ev = 4'b0001 << ew[DW-1:DW-2];
               if (push_v !== ev || dpu[ew[DW-1:DW-2]] !== ew) begin
                  mismatched++; $display("FAIL mid_push: got %b/%h, expected %b/%h", push_v, dpu[ew[DW-1:DW-2]], ev, ew);
               end
            end
         end
      end
      compared++;
      if (exp_pop.size() != 0 || exp_push.size() != 0) begin
         mismatched++; $display("FAIL mid_leftover: got %0d/%0d pending, expected 0/0", exp_pop.size(), exp_push.size());
         exp_pop.delete(); exp_push.delete();
      end
   endtask

`ifdef ARB_PUSH_CNT_EN
   task automatic test_push_cnt();
      logic [3:0]    ep, ev;
      logic [DW-1:0] ew;
      logic [7:0]    exp_cnt;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 130; i++) begin
         load(0, {2'b11, 8'(2 * i)});
         load(1, {2'b11, 8'(2 * i + 1)});
         expect_word(0, {2'b11, 8'(2 * i)});
         expect_word(1, {2'b11, 8'(2 * i + 1)});
      end
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (pop_v != 4'h0) begin
            compared++;
            if (exp_pop.size() == 0) begin mismatched++; $display("FAIL cnt_pop: got %b, expected none", pop_v); end
            else begin
               ep = exp_pop.pop_front();
               if (pop_v !== ep) begin mismatched++; $display("FAIL cnt_pop: got %b, expected %b", pop_v, ep); end
            end
         end
         if (push_v != 4'h0) begin
            compared++;
            if (exp_push.size() == 0) begin mismatched++; $display("FAIL cnt_push: got %b, expected none", push_v); end
            else begin
               ew = exp_push.pop_front();
               ev = 4'b0001 << ew[DW-1:DW-2];
               if (push_v !== ev || dpu[ew[DW-1:DW-2]] !== ew) begin
                  mismatched++; $display("FAIL cnt_push: got %b/%h, expected %b/%h", push_v, dpu[ew[DW-1:DW-2]], ev, ew);
               end
            end
         end
      end
      compared++;
      if (exp_pop.size() != 0 || exp_push.size() != 0) begin
         mismatched++; $display("FAIL cnt_leftover: got %0d/%0d pending, expected 0/0", exp_pop.size(), exp_push.size());
         exp_pop.delete(); exp_push.delete();
      end
      for (int s = 0; s < 4; s++) begin
         cnt_sel = 2'(s);
         #1;
         exp_cnt = (s == 3) ? 8'd4 : 8'd0;
         compared++;
         if (cnt_out !== exp_cnt) begin mismatched++; $display("FAIL cnt_sel%0d: got %0d, expected %0d", s, cnt_out, exp_cnt); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_rotation();
      test_single_port();
      test_alm_full_hold();
      test_en_drop();
      test_reset_mid();
`ifdef ARB_PUSH_CNT_EN
      test_push_cnt();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
